// File: rtl/if_stage_ctrl.sv
// if_stage_ctrl: fetch-stage PC and IF/ID register control with stall, branch flush and HLT drain/halt.
module if_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        IF_Flush,
  input  logic        ID_Flush,
  input  logic [15:0] br_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] IF_ID_Inst,
  output logic [15:0] IF_ID_PCplus2,
  output logic        IF_ID_valid,
  output logic        ID_EX_bubble,
  output logic        halt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, nextState;
  logic [15:0] pc, nextPc, nextInst, nextPcPlus2, pcPlus2;
  logic [1:0] cnt, nextCnt;
  logic nextValid, isHlt;
  assign imem_addr = pc;
  assign pcPlus2 = pc + 16'd2;
  assign isHlt = imem_data[15:12] == 4'b1111;
  assign ID_EX_bubble = ID_Flush | stall;
  always_comb begin
    nextState = state;
    nextPc = pc;
    nextInst = IF_ID_Inst;
    nextPcPlus2 = IF_ID_PCplus2;
    nextValid = IF_ID_valid;
    nextCnt = cnt;
    if (!stall && state == RUN) begin
      if (IF_Flush) begin
        nextPc = br_target;
        nextInst = 16'h0000;
        nextValid = 1'b0;
      end else begin
        nextInst = imem_data;
        nextPcPlus2 = pcPlus2;
        nextValid = 1'b1;
        nextPc = isHlt ? pc : pcPlus2;
        nextState = isHlt ? DRAIN : RUN;
        nextCnt = isHlt ? 2'd3 : cnt;
      end
    end else if (!stall && state == DRAIN) begin
      // HLT is the youngest instruction, so a branch flush here has nothing to redirect
      nextInst = 16'h0000;
      nextValid = 1'b0;
      nextState = cnt == 2'd0 ? HALTED : DRAIN;
      nextCnt = cnt == 2'd0 ? cnt : cnt - 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc <= 16'h0000;
      IF_ID_Inst <= 16'h0000;
      IF_ID_PCplus2 <= 16'h0000;
      IF_ID_valid <= 1'b0;
      cnt <= 2'd0;
      halt <= 1'b0;
    end else begin
      state <= nextState;
      pc <= nextPc;
      IF_ID_Inst <= nextInst;
      IF_ID_PCplus2 <= nextPcPlus2;
      IF_ID_valid <= nextValid;
      cnt <= nextCnt;
      halt <= state == HALTED;
    end
  end
endmodule

// File: doc/if_stage_ctrl.md
IF_STAGE_CTRL -- requirements
Module: if_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port stall, input, 1: hazard-unit stall request (load-use or unresolved branch flags).
REQ-004 SHALL have port IF_Flush, input, 1: taken branch in ID; discard the fetched instruction and redirect.
REQ-005 SHALL have port ID_Flush, input, 1: request a bubble into ID/EX.
REQ-006 SHALL have port br_target, input, 16: branch target PC, valid with IF_Flush.
REQ-007 SHALL have port imem_data, input, 16: instruction word at imem_addr, same-cycle combinational read.
REQ-008 SHALL have port imem_addr, output, 16: current PC.
REQ-009 SHALL have port IF_ID_Inst, output, 16: registered instruction presented to ID.
REQ-010 SHALL have port IF_ID_PCplus2, output, 16: registered PC+2 of IF_ID_Inst.
REQ-011 SHALL have port IF_ID_valid, output, 1: IF_ID_Inst is a real instruction, not a bubble.
REQ-012 SHALL have port ID_EX_bubble, output, 1: ID/EX register loads a bubble this cycle.
REQ-013 SHALL have port halt, output, 1: processor halted, registered.

Function
REQ-014 SHALL hold PC in a 16-bit register; PC+2 wraps 0xFFFE -> 0x0000.
REQ-015 SHALL encode a bubble as IF_ID_Inst=16'h0000, IF_ID_valid=0, IF_ID_PCplus2 unchanged.
REQ-016 SHALL drive ID_EX_bubble = ID_Flush | stall, combinationally.
REQ-017 SHALL apply this per-cycle priority: stall > IF_Flush > halt detect > normal fetch.
REQ-018 stall=1: PC, IF_ID_Inst, IF_ID_PCplus2, IF_ID_valid all hold; IF_Flush ignored that cycle.
REQ-019 IF_Flush=1 and stall=0: PC <= br_target; IF_ID loads bubble; any halt detect that cycle is cancelled.
REQ-020 Normal fetch in RUN: IF_ID_Inst <= imem_data, IF_ID_PCplus2 <= PC+2, IF_ID_valid <= 1, PC <= PC+2.
REQ-021 SHALL implement FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-022 RUN -> DRAIN: normal fetch with imem_data[15:12]==4'b1111 (HLT); HLT loads into IF_ID; PC holds at the HLT address; 2-bit drain counter <= 3.
REQ-023 DRAIN: IF_ID loads bubbles; PC holds; counter decrements each cycle stall=0 and holds while stall=1.
REQ-024 DRAIN -> HALTED: cycle after counter==0 with stall=0; halt <= 1.
REQ-025 IF_Flush during DRAIN SHALL be ignored, since the HLT is the youngest instruction.
REQ-026 HALTED: halt=1, PC and IF_ID frozen, IF_ID_valid=0; exit only by reset.
REQ-027 imem_addr SHALL equal PC at all times.

Reset
REQ-028 rst_n=0 SHALL force asynchronously: PC=0x0000, IF_ID_Inst=0x0000, IF_ID_PCplus2=0x0000, IF_ID_valid=0, halt=0, FSM=RUN, counter=0.
REQ-029 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN with the reset values above, no residual halt.
REQ-030 First fetch after rst_n rises SHALL be from address 0x0000 on the first rising edge.

Verification
REQ-031 Sequential fetch: imem returns 0x1234, 0x5678 at 0x0000, 0x0002 -> IF_ID_Inst 0x1234 (PCplus2 0x0002), then 0x5678 (0x0004), valid=1.
REQ-032 Stall: stall=1 for 2 cycles with PC=0x0004 -> PC stays 0x0004, IF_ID held, ID_EX_bubble=1 both cycles, fetch resumes after.
REQ-033 Taken branch: IF_Flush=1, br_target=0x0040 -> next cycle PC=0x0040, IF_ID_valid=0; next fetch has PCplus2 0x0042.
REQ-034 Stall+flush same cycle: stall=1, IF_Flush=1, br_target=0x0080 -> PC unchanged, no redirect.
REQ-035 Halt: HLT 0xF000 fetched at 0x000A -> IF_ID_Inst=0xF000, PC held 0x000A, bubbles follow, halt=1 exactly 5 cycles after the HLT fetch edge; HLT fetched with IF_Flush=1 -> no halt, PC=br_target.
REQ-036 Wrap and reset: PC=0xFFFE fetch -> PC=0x0000; rst_n low in HALTED -> halt=0, PC=0x0000 immediately, without waiting for a clock edge.
